branch_direction_predictor: RTL and testbench

- Fetch-stage next-PC unit, directly downstream of the BTB.
- Consumes the BTB hit/target for `current_pc` and gates it with a table of 2-bit saturating direction counters to produce `next_pc`.
- Takes resolved-branch updates from EX, trains the counters, and raises a same-cycle redirect on misprediction.
- Keeps branch and mispredict statistics counters.

---
 rtl/branch_direction_predictor_pkg.sv | 15 +
 rtl/sat_counter2.sv | 19 +
 rtl/branch_direction_predictor.sv | 84 ++++++++
 tb/tb_branch_direction_predictor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_direction_predictor_pkg.sv
// Shared encodings and constants for the fetch-stage branch direction predictor.
package branch_direction_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  localparam int unsigned IDX_BITS_DEFAULT = 5;
  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic used to train the direction table.
module sat_counter2
  import branch_direction_predictor_pkg::*;
(
  input  logic [1:0] cnt_cur,
  input  logic       inc,
  output logic [1:0] cnt_next_c
);

  always_comb begin
    cnt_next_c = cnt_cur;
    if (inc) begin
      if (cnt_cur != ST) cnt_next_c = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != SNT) cnt_next_c = cnt_cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_direction_predictor.sv
// Next-PC unit: gates BTB hits with 2-bit direction counters, trains on EX resolution, flags mispredicts.
// Optional build macro GSHARE_EN folds a non-speculative global history register into the fetch index.
module branch_direction_predictor
  import branch_direction_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_BITS_DEFAULT,
  parameter logic [1:0]  CNT_INIT = WNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  input  logic                btb_tag_match,
  input  logic [31:0]         btb_target_pc,
  output logic [31:0]         next_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [IDX_BITS-1:0] update_idx,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic [31:0]         update_pred_next_pc,
  output logic                flush,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  logic [1:0]          cnt_q [DEPTH];
  logic [IDX_BITS-1:0] fetch_idx;
  logic [31:0]         actual_pc;
  logic [1:0]          cnt_upd;

`ifdef GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;
  assign fetch_idx = current_pc[IDX_BITS+1:2] ^ ghr_q;
`else
  assign fetch_idx = current_pc[IDX_BITS+1:2];
`endif

  // Prediction and resolve paths are zero-latency; reset forces the idle values.
  always_comb begin
    pred_idx    = fetch_idx;
    pred_taken  = reset & btb_tag_match & cnt_q[fetch_idx][1];
    actual_pc   = update_taken ? update_target : update_pc + PC_INC;
    flush       = reset & update_valid & (actual_pc != update_pred_next_pc);
    redirect_pc = flush ? actual_pc : 32'b0;
    if (flush) begin
      next_pc = redirect_pc;
    end else if (pred_taken) begin
      next_pc = btb_target_pc;
    end else begin
      next_pc = current_pc + PC_INC;
    end
  end

  sat_counter2 u_sat_counter2 (
    .cnt_cur    (cnt_q[update_idx]),
    .inc        (update_taken),
    .cnt_next_c (cnt_upd)
  );

  // Training is committed even when the same update raises a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
      branch_count     <= 32'b0;
      mispredict_count <= 32'b0;
`ifdef GSHARE_EN
      ghr_q            <= '0;
`endif
    end else if (update_valid) begin
      cnt_q[update_idx] <= cnt_upd;
      branch_count      <= branch_count + 32'd1;
      if (flush) mispredict_count <= mispredict_count + 32'd1;
`ifdef GSHARE_EN
      ghr_q             <= {ghr_q[IDX_BITS-2:0], update_taken};
`endif
    end
  end

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Directed scoreboard bench for branch_direction_predictor and its sat_counter2 helper.
module tb_branch_direction_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc, btb_target_pc, next_pc;
  logic        btb_tag_match, pred_taken;
  logic [4:0]  pred_idx, update_idx;
  logic        update_valid, update_taken, flush;
  logic [31:0] update_pc, update_target, update_pred_next_pc, redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  logic [1:0]  uc_cur, uc_next;
  logic        uc_inc;

  int unsigned total = 0;
  int unsigned passed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_direction_predictor dut (
    .clk                 (clk),
    .reset               (reset),
    .current_pc          (current_pc),
    .btb_tag_match       (btb_tag_match),
    .btb_target_pc       (btb_target_pc),
    .next_pc             (next_pc),
    .pred_taken          (pred_taken),
    .pred_idx            (pred_idx),
    .update_valid        (update_valid),
    .update_pc           (update_pc),
    .update_idx          (update_idx),
    .update_taken        (update_taken),
    .update_target       (update_target),
    .update_pred_next_pc (update_pred_next_pc),
    .flush               (flush),
    .redirect_pc         (redirect_pc),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  sat_counter2 u_unit (
    .cnt_cur    (uc_cur),
    .inc        (uc_inc),
    .cnt_next_c (uc_next)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "next_pc":     return next_pc;
      "pred_taken":  return 32'(pred_taken);
      "pred_idx":    return 32'(pred_idx);
      "flush":       return 32'(flush);
      "redirect_pc": return redirect_pc;
      "branch_cnt":  return branch_count;
      "mispred_cnt": return mispredict_count;
      "sat_next":    return 32'(uc_next);
      default:       return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Pop every pending expectation and compare it with the live DUT value.
  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.tag);
      total++;
      assert (o === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    current_pc    = pc;
    btb_tag_match = hit;
    btb_target_pc = tgt;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [4:0] idx,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] pnext);
    update_valid        = v;
    update_pc           = pc;
    update_idx          = idx;
    update_taken        = tk;
    update_target       = tgt;
    update_pred_next_pc = pnext;
  endtask

  task automatic expect_counts(input logic [31:0] b, input logic [31:0] m);
    expect_val("branch_cnt", b);
    expect_val("mispred_cnt", m);
  endtask

  initial begin
    logic [1:0] exp_n;
    reset = 1'b0;
    set_fetch(32'h100, 1'b1, 32'h200);
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);

    // Saturating counter unit: every state in both directions.
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        uc_cur = 2'(c);
        uc_inc = d[0];
        if (d == 1) exp_n = (c == 3) ? 2'd3 : 2'(c + 1);
        else        exp_n = (c == 0) ? 2'd0 : 2'(c - 1);
        expect_val("sat_next", 32'(exp_n));
        drain();
      end
    end

    // Held in reset.
    expect_val("pred_taken", 32'd0);
    expect_val("next_pc", 32'h104);
    expect_val("flush", 32'd0);
    expect_val("redirect_pc", 32'd0);
    expect_counts(32'd0, 32'd0);
    drain();

    @(negedge clk);
    reset = 1'b1;
    expect_val("pred_taken", 32'd0);
    expect_val("next_pc", 32'h104);
    expect_val("pred_idx", 32'd0);
    expect_val("flush", 32'd0);
    expect_counts(32'd0, 32'd0);
    drain();

`ifdef GSHARE_EN
    // History T,T,NT gives ghr=00110, so fetch of 0x100 indexes entry 6.
    @(negedge clk); set_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h200, 32'h200);
    @(negedge clk); set_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h200, 32'h200);
    @(negedge clk); set_upd(1'b1, 32'h100, 5'd0, 1'b0, 32'h200, 32'h104);
    @(negedge clk); set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    set_fetch(32'h100, 1'b1, 32'h200);
    expect_val("pred_idx", 32'd6);
    expect_counts(32'd3, 32'd0);
    drain();
`else
    // Two taken updates at idx 0 while fetch predicted fall-through: both mispredict.
    @(negedge clk);
    set_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h200, 32'h104);
    expect_val("pred_taken", 32'd0);
    expect_val("flush", 32'd1);
    expect_val("redirect_pc", 32'h200);
    expect_val("next_pc", 32'h200);
    drain();

    @(negedge clk);
    set_fetch(32'h100, 1'b1, 32'h300);
    expect_val("pred_taken", 32'd1);
    expect_val("flush", 32'd1);
    expect_val("redirect_pc", 32'h200);
    expect_val("next_pc", 32'h200);
    expect_counts(32'd1, 32'd1);
    drain();

    @(negedge clk);
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    set_fetch(32'h100, 1'b1, 32'h200);
    expect_val("pred_taken", 32'd1);
    expect_val("next_pc", 32'h200);
    expect_val("flush", 32'd0);
    expect_val("redirect_pc", 32'd0);
    expect_counts(32'd2, 32'd2);
    drain();

    // Four not-taken then one taken; each cycle sees the pre-update counter (11,10,01,00,00).
    @(negedge clk);
    set_upd(1'b1, 32'h100, 5'd0, 1'b0, 32'h200, 32'h104);
    expect_val("pred_taken", 32'd1);
    expect_val("flush", 32'd0);
    drain();
    @(negedge clk);
    expect_val("pred_taken", 32'd1);
    expect_val("flush", 32'd0);
    drain();
    @(negedge clk);
    expect_val("pred_taken", 32'd0);
    expect_val("flush", 32'd0);
    expect_val("next_pc", 32'h104);
    drain();
    @(negedge clk);
    expect_val("pred_taken", 32'd0);
    drain();
    @(negedge clk);
    set_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h200, 32'h200);
    expect_val("pred_taken", 32'd0);
    expect_val("flush", 32'd0);
    drain();
    @(negedge clk);
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_val("pred_taken", 32'd0);
    expect_counts(32'd7, 32'd2);
    drain();

    // Same-index read and write: prediction uses the old value this cycle.
    @(negedge clk);
    set_fetch(32'h10C, 1'b1, 32'h500);
    set_upd(1'b1, 32'h10C, 5'd3, 1'b1, 32'h400, 32'h400);
    expect_val("pred_idx", 32'd3);
    expect_val("pred_taken", 32'd0);
    expect_val("next_pc", 32'h110);
    drain();
    @(negedge clk);
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_val("pred_taken", 32'd1);
    expect_val("next_pc", 32'h500);
    drain();

    // 32-bit wraparound on both PC adders.
    @(negedge clk);
    set_fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
    set_upd(1'b1, 32'hFFFF_FFFC, 5'd31, 1'b0, 32'h0, 32'h0);
    expect_val("next_pc", 32'h0);
    expect_val("flush", 32'd0);
    drain();

    // Mispredicting update, then an async reset pulse between edges.
    @(negedge clk);
    set_fetch(32'h10C, 1'b1, 32'h500);
    set_upd(1'b1, 32'h10C, 5'd3, 1'b1, 32'h700, 32'h110);
    expect_val("flush", 32'd1);
    expect_val("redirect_pc", 32'h700);
    expect_counts(32'd9, 32'd2);
    drain();
    #1 reset = 1'b0;
    expect_val("pred_taken", 32'd0);
    expect_val("flush", 32'd0);
    expect_val("redirect_pc", 32'd0);
    expect_val("next_pc", 32'h110);
    expect_counts(32'd0, 32'd0);
    drain();
    @(negedge clk);
    expect_counts(32'd0, 32'd0);
    drain();
    reset = 1'b1;
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_val("pred_taken", 32'd0);
    drain();

    // First edge after release trains immediately.
    @(negedge clk);
    set_upd(1'b1, 32'h10C, 5'd3, 1'b1, 32'h700, 32'h700);
    expect_val("flush", 32'd0);
    drain();
    @(negedge clk);
    set_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    expect_val("pred_taken", 32'd1);
    expect_val("next_pc", 32'h500);
    expect_counts(32'd1, 32'd0);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
